// File: rtl/popcount_seq_if.sv
// popcount_seq_if -- operand/result bundle for the sequential popcount engine.
//
// Signals:
//   in_valid / in_ready    operand handshake (requester -> engine)
//   mode                   0 = popcount(a), 1 = popcount(a ^ b)
//   a, b                   WIDTH-bit operands (b ignored when mode = 0)
//   out_valid / out_ready  result handshake (engine -> consumer)
//   count                  CW-bit result
//   busy                   engine is in RUN or DONE
//   thresh, over           early-termination threshold and flag, present only
//                          when POPCOUNT_SEQ_THRESH_EN is defined
//
// Modports: master = requester/consumer side, slave = engine side.

interface popcount_seq_if #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    count;
   logic             busy;
`ifdef POPCOUNT_SEQ_THRESH_EN
   logic [CW-1:0]    thresh;
   logic             over;

   modport master (
      output in_valid, mode, a, b, out_ready, thresh,
      input  in_ready, out_valid, count, busy, over
   );
   modport slave (
      input  in_valid, mode, a, b, out_ready, thresh,
      output in_ready, out_valid, count, busy, over
   );
`else
   modport master (
      output in_valid, mode, a, b, out_ready,
      input  in_ready, out_valid, count, busy
   );
   modport slave (
      input  in_valid, mode, a, b, out_ready,
      output in_ready, out_valid, count, busy
   );
`endif
endinterface

// File: rtl/popcount_seq.sv
// popcount_seq -- multi-cycle popcount / Hamming-distance engine.
//
// Counts the ones of a WIDTH-bit operand CHUNK bits per clock. The operand is
// either a (mode = 0) or a ^ b (mode = 1), captured on the input handshake.
// After WIDTH/CHUNK RUN cycles the result is presented in DONE until the
// consumer takes it.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    popcount_seq_if.slave: in_valid/in_ready, mode, a, b,
//          out_valid/out_ready, count, busy (+ thresh/over when enabled)
//
// Optional feature (macro POPCOUNT_SEQ_THRESH_EN): a threshold captured at
// accept; RUN stops as soon as the running sum exceeds it, and over reports
// count > thresh alongside out_valid.

module popcount_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input logic           clk,
   input logic           rst_n,
   popcount_seq_if.slave bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int PW  = $clog2(CHUNK + 1);
   // chunk index needs at least one bit even when a single chunk covers WIDTH
   localparam int NCW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CW-1:0]    acc_reg, acc_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [NCW-1:0]   chunk_reg, chunk_next;
   logic [PW-1:0]    chunk_pop;
   logic [CW-1:0]    sum;
   logic             last_chunk;
   logic             early;

`ifdef POPCOUNT_SEQ_THRESH_EN
   logic [CW-1:0]    thresh_reg, thresh_next;
   logic             over_reg, over_next;

   // sum already includes this cycle's chunk, so the decision is made on the
   // same edge that would otherwise just advance the accumulator
   assign early = (sum > thresh_reg);
`else
   assign early = 1'b0;
`endif

   // ones in the low chunk of the shift register
   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_pop = chunk_pop + PW'(shift_reg[i]);
      end
   end

   assign sum        = acc_reg + CW'(chunk_pop);
   assign last_chunk = (chunk_reg == NCW'(NCH - 1));

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      acc_next   = acc_reg;
      count_next = count_reg;
      chunk_next = chunk_reg;
`ifdef POPCOUNT_SEQ_THRESH_EN
      thresh_next = thresh_reg;
      over_next   = over_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               shift_next = bus.mode ? (bus.a ^ bus.b) : bus.a;
               acc_next   = '0;
               chunk_next = '0;
`ifdef POPCOUNT_SEQ_THRESH_EN
               thresh_next = bus.thresh;
`endif
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next   = sum;
            shift_next = shift_reg >> CHUNK;
            chunk_next = chunk_reg + NCW'(1);
            if (last_chunk || early) begin
               count_next = sum;
`ifdef POPCOUNT_SEQ_THRESH_EN
               // on full completion sum is the final count, so the same
               // comparison yields count > thresh
               over_next = early;
`endif
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         acc_reg   <= '0;
         count_reg <= '0;
         chunk_reg <= '0;
`ifdef POPCOUNT_SEQ_THRESH_EN
         thresh_reg <= '0;
         over_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         acc_reg   <= acc_next;
         count_reg <= count_next;
         chunk_reg <= chunk_next;
`ifdef POPCOUNT_SEQ_THRESH_EN
         thresh_reg <= thresh_next;
         over_reg   <= over_next;
`endif
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.count     = count_reg;
`ifdef POPCOUNT_SEQ_THRESH_EN
   assign bus.over      = over_reg;
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq -- directed bench for popcount_seq.
//
// Four engines (CHUNK = 8, 1, 4, 32; WIDTH = 32) share the same stimulus so
// every transaction also checks the latency of each chunk size. Index 0 is
// the CHUNK = 8 instance used for the directed boundary cases.

module tb_popcount_seq;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        mode;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_ready;
   logic [5:0]  thresh_in;

   logic [3:0]       ov;
   logic [3:0]       rdy;
   logic [3:0]       bsy;
   logic [3:0][5:0]  cnt;
   logic [3:0]       over_o;

   int checks;
   int errors;
   int exp_lat [4];
   int exp_cnt [4];
   int exp_over [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dut
         localparam int CH = (gi == 0) ? 8 : (gi == 1) ? 1 : (gi == 2) ? 4 : 32;
         popcount_seq_if #(.WIDTH(32), .CW(6)) u_if ();
         popcount_seq #(.WIDTH(32), .CHUNK(CH), .CW(6)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
         );
         assign u_if.in_valid  = in_valid;
         assign u_if.mode      = mode;
         assign u_if.a         = a;
         assign u_if.b         = b;
         assign u_if.out_ready = out_ready;
         assign ov[gi]         = u_if.out_valid;
         assign rdy[gi]        = u_if.in_ready;
         assign bsy[gi]        = u_if.busy;
         assign cnt[gi]        = u_if.count;
`ifdef POPCOUNT_SEQ_THRESH_EN
         assign u_if.thresh    = thresh_in;
         assign over_o[gi]     = u_if.over;
`else
         assign over_o[gi]     = 1'b0;
`endif
      end
   endgenerate

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_full(input int v);
      exp_lat[0] = 4;  exp_lat[1] = 32; exp_lat[2] = 8; exp_lat[3] = 1;
      for (int i = 0; i < 4; i++) begin
         exp_cnt[i]  = v;
         exp_over[i] = 0;
      end
   endtask

   // One transaction on all four engines; hold = extra DONE cycles with
   // out_ready low and stray in_valid pulses.
   task automatic run_op(input logic m, input logic [31:0] va, input logic [31:0] vb,
                         input int hold, input string tag);
      int  lat [4];
      bit  all_done;
      mode     = m;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      step();
      check({tag, "/busy_after_accept"}, bsy, 4'hF);
      // inputs change after the accept edge and must not matter
      in_valid = 1'b0;
      mode     = ~m;
      a        = ~va;
      b        = $urandom;
      for (int i = 0; i < 4; i++) lat[i] = 0;
      all_done = 1'b0;
      for (int c = 1; c <= 40 && !all_done; c++) begin
         step();
         all_done = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (lat[i] == 0 && ov[i]) lat[i] = c;
            if (lat[i] == 0) all_done = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s/lat%0d", tag, i), lat[i], exp_lat[i]);
         check($sformatf("%s/count%0d", tag, i), cnt[i], exp_cnt[i]);
`ifdef POPCOUNT_SEQ_THRESH_EN
         check($sformatf("%s/over%0d", tag, i), over_o[i], exp_over[i]);
`endif
      end
      $display("op %s mode=%0d a=%h b=%h count=%0d lat=%0d", tag, m, va, vb, cnt[0], lat[0]);
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         a        = $urandom;
         step();
         check($sformatf("%s/hold%0d_valid", tag, h), ov, 4'hF);
         check($sformatf("%s/hold%0d_ready", tag, h), rdy, 4'h0);
         check($sformatf("%s/hold%0d_count", tag, h), cnt[0], exp_cnt[0]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "/out_valid_after_hs"}, ov, 4'h0);
      check({tag, "/in_ready_after_hs"}, rdy, 4'hF);
      check({tag, "/busy_after_hs"}, bsy, 4'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        m;
      logic [31:0] va;
      logic [31:0] vb;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      mode      = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      thresh_in = 6'h3F;
      step();
      step();
      check("reset/in_ready", rdy, 4'hF);
      check("reset/out_valid", ov, 4'h0);
      check("reset/busy", bsy, 4'h0);
      check("reset/count", cnt, '0);
      check("reset/over", over_o, 4'h0);
      rst_n = 1'b1;
      step();

      set_full(32); run_op(1'b0, 32'hFFFF_FFFF, 32'h0, 0, "ones");
      set_full(32); run_op(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, "ham_all");
      set_full(0);  run_op(1'b1, 32'h1234_5678, 32'h1234_5678, 0, "ham_equal");
      set_full(1);  run_op(1'b1, 32'h0000_0001, 32'h0000_0003, 0, "ham_one");
      set_full(2);  run_op(1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 5, "backpressure");
      set_full(0);  run_op(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 0, "zeros");

      // reset during RUN cycle 2
      mode     = 1'b0;
      a        = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("midreset/busy_before", bsy, 4'hF);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midreset/in_ready", rdy, 4'hF);
      check("midreset/out_valid", ov, 4'h0);
      check("midreset/count", cnt, '0);
      check("midreset/busy", bsy, 4'h0);
      step();
      check("midreset/no_result", ov, 4'h0);
      $display("op midreset aborted count=%0d", cnt[0]);
      set_full(4); run_op(1'b0, 32'h0000_000F, 32'h0, 0, "after_reset");

      for (int r = 0; r < 4; r++) begin
         m  = 1'($urandom_range(0, 1));
         va = $urandom;
         vb = $urandom;
         set_full($countones(m ? (va ^ vb) : va));
         run_op(m, va, vb, 0, $sformatf("rand%0d", r));
      end

`ifdef POPCOUNT_SEQ_THRESH_EN
      // 0xFF with thresh 5: sums after each RUN cycle exceed 5 at
      // CHUNK=8 cycle 1 (8), CHUNK=1 cycle 6 (6), CHUNK=4 cycle 2 (8)
      thresh_in = 6'd5;
      exp_lat[0] = 1; exp_lat[1] = 6; exp_lat[2] = 2; exp_lat[3] = 1;
      exp_cnt[0] = 8; exp_cnt[1] = 6; exp_cnt[2] = 8; exp_cnt[3] = 8;
      for (int i = 0; i < 4; i++) exp_over[i] = 1;
      run_op(1'b0, 32'h0000_00FF, 32'h0, 0, "thresh5");
      thresh_in = 6'd8;
      set_full(8);
      run_op(1'b0, 32'h0000_00FF, 32'h0, 0, "thresh8");
      thresh_in = 6'h3F;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
